// File: rtl/button_conditioner.sv
// Per-button synchroniser, debouncer and edge/long-press detector.
// Every channel is an identical, independent copy of the same pipeline.
module button_conditioner #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    localparam int DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HCNT_W = $clog2(LONG_CYCLES) + 1;
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(LONG_CYCLES - 1);

    genvar g;
    generate
        for (g = 0; g < N_BTN; g++) begin : g_chan
            logic              r_s1;
            logic              r_s2;
            logic              r_lvl;
            logic              r_press;
            logic              r_release;
            logic              r_long;
            logic              r_long_done;
            logic [DCNT_W-1:0] r_dcnt;
            logic [HCNT_W-1:0] r_hcnt;
            logic              w_flip;

            // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            assign w_flip = (r_s2 != r_lvl) && (r_dcnt == DCNT_MAX);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_s1      <= 1'b0;
                    r_s2      <= 1'b0;
                    r_lvl     <= 1'b0;
                    r_dcnt    <= '0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_s1      <= btn_in[g];
                    r_s2      <= r_s1;
                    r_press   <= w_flip & r_s2;
                    r_release <= w_flip & ~r_s2;
                    if (r_s2 == r_lvl) begin
                        r_dcnt <= '0;
                    end else if (w_flip) begin
                        r_lvl  <= r_s2;
                        r_dcnt <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
            end

            // Hold counter stops at its terminal value, so one press gives at most one long pulse.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_hcnt      <= '0;
                    r_long      <= 1'b0;
                    r_long_done <= 1'b0;
                end else begin
                    r_long <= 1'b0;
                    if (!r_lvl) begin
                        r_hcnt      <= '0;
                        r_long_done <= 1'b0;
                    end else if (!r_long_done) begin
                        if (r_hcnt == HCNT_MAX) begin
                            r_long      <= 1'b1;
                            r_long_done <= 1'b1;
                        end else begin
                            r_hcnt <= r_hcnt + 1'b1;
                        end
                    end
                end
            end

            assign btn_level[g]   = r_lvl;
            assign btn_press[g]   = r_press;
            assign btn_release[g] = r_release;
            assign btn_long[g]    = r_long;
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing,
// every cycle compared against a window-based reference model.
module tb_button_conditioner;

    localparam int N  = 3;
    localparam int D  = 4;
    localparam int L  = 10;
    localparam int HL = D + 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    button_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_long(btn_long)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples per edge, level flips when the D
    // synchronised samples ending at this edge all disagree with it.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_lvl, m_press, m_rel, m_long;
    int           m_pcyc[N];

    // Pulse tallies observed from the DUT for directed expectations.
    int n_press[N], n_rel[N], n_long[N];
    int f_press[N], f_rel[N], f_long[N];

    task automatic model_clear();
        hist.delete();
        for (int i = 0; i < HL; i++) hist.push_back('0);
        m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
        for (int c = 0; c < N; c++) m_pcyc[c] = -1000;
    endtask

    task automatic model_edge(input logic [N-1:0] raw);
        if (reset) begin
            model_clear();
        end else begin
            for (int c = 0; c < N; c++) begin
                bit flip;
                flip = 1'b1;
                for (int j = 0; j < D; j++)
                    if (hist[HL-2-j][c] == m_lvl[c]) flip = 1'b0;
                m_press[c] = flip && !m_lvl[c];
                m_rel[c]   = flip && m_lvl[c];
                m_long[c]  = m_lvl[c] && ((cyc - m_pcyc[c]) == L);
                if (flip) m_lvl[c] = !m_lvl[c];
                if (m_press[c]) m_pcyc[c] = cyc;
            end
            hist.push_back(raw);
            void'(hist.pop_front());
        end
    endtask

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("level",   btn_level,   m_lvl);
        chk("press",   btn_press,   m_press);
        chk("release", btn_release, m_rel);
        chk("long",    btn_long,    m_long);
    endtask

    task automatic clear_tally();
        for (int c = 0; c < N; c++) begin
            n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0;
            f_press[c] = -1; f_rel[c] = -1; f_long[c] = -1;
        end
    endtask

    task automatic tally();
        for (int c = 0; c < N; c++) begin
            if (btn_press[c])   begin n_press[c]++; if (f_press[c] < 0) f_press[c] = cyc; end
            if (btn_release[c]) begin n_rel[c]++;   if (f_rel[c] < 0)   f_rel[c]   = cyc; end
            if (btn_long[c])    begin n_long[c]++;  if (f_long[c] < 0)  f_long[c]  = cyc; end
        end
    endtask

    // Drive inputs, take one edge, update the model, sample 1 ns later.
    task automatic step(input logic [N-1:0] b);
        btn_in = b;
        @(posedge clk);
        cyc++;
        model_edge(b);
        #1;
        check_outputs();
        tally();
    endtask

    task automatic steps(input logic [N-1:0] b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    int t0;
    int hold[N];
    logic [N-1:0] rnd;

    initial begin
        model_clear();
        clear_tally();

        // Reset held over a few edges, then idle.
        steps(3'b000, 3);
        chk("reset_level", btn_level, 3'b000);
        reset = 1'b0;
        clear_tally();
        steps(3'b000, 20);
        chk_int("idle_press",   n_press[0] + n_press[1] + n_press[2], 0);
        chk_int("idle_release", n_rel[0] + n_rel[1] + n_rel[2], 0);
        chk_int("idle_long",    n_long[0] + n_long[1] + n_long[2], 0);

        // Single press on channel 1: press six edges after the drive.
        clear_tally();
        t0 = cyc;
        steps(3'b010, 6);
        chk_int("ch1_press_edge", f_press[1], t0 + 6);
        chk("ch1_level_at_press", btn_level, 3'b010);
        step(3'b010);
        chk("ch1_press_low_next", btn_press, 3'b000);
        chk_int("ch1_others_press", n_press[0] + n_press[2], 0);

        // Reset two cycles after the press while the button stays held.
        steps(3'b010, 1);
        reset = 1'b1;
        #1;
        model_clear();
        chk("rst_level",   btn_level,   3'b000);
        chk("rst_press",   btn_press,   3'b000);
        chk("rst_release", btn_release, 3'b000);
        chk("rst_long",    btn_long,    3'b000);
        clear_tally();
        steps(3'b010, 2);
        chk_int("rst_no_long", n_long[1], 0);
        reset = 1'b0;
        t0 = cyc;
        steps(3'b010, 8);
        chk_int("rst_repress_edge", f_press[1], t0 + 6);
        chk_int("rst_repress_once", n_press[1], 1);
        steps(3'b000, 10);

        // Bounce on channel 0 then steady high: one press, no release.
        clear_tally();
        steps(3'b001, 2); steps(3'b000, 2);
        steps(3'b001, 2); steps(3'b000, 2);
        t0 = cyc;
        steps(3'b001, 10);
        chk_int("bounce_press_count", n_press[0], 1);
        chk_int("bounce_press_edge",  f_press[0], t0 + 6);
        chk_int("bounce_no_release",  n_rel[0], 0);
        steps(3'b000, 10);

        // Long hold on channel 2.
        clear_tally();
        t0 = cyc;
        steps(3'b100, 30);
        chk_int("hold_press_edge", f_press[2], t0 + 6);
        t0 = cyc;
        steps(3'b000, 10);
        chk_int("hold_press_once", n_press[2], 1);
        chk_int("hold_long_once",  n_long[2], 1);
        chk_int("hold_long_edge",  f_long[2], f_press[2] + L);
        chk_int("hold_rel_once",   n_rel[2], 1);
        chk_int("hold_rel_edge",   f_rel[2], t0 + 6);

        // Simultaneous press on channels 0 and 2.
        clear_tally();
        t0 = cyc;
        steps(3'b101, 8);
        chk_int("simul_press0", f_press[0], t0 + 6);
        chk_int("simul_press2", f_press[2], t0 + 6);
        steps(3'b000, 10);

        // Random bouncing mixed with long holds on all channels.
        rnd = '0;
        for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 20);
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    rnd[c] = ~rnd[c];
                    hold[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3)
                                                          : $urandom_range(4, 25);
                end
                hold[c]--;
            end
            step(rnd);
        end
        steps(3'b000, 20);
        chk("final_level", btn_level, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Synchronises, debounces and edge-detects the raw push-buttons (left/up/down) before they reach the calculator's state-selection, number-system and reset logic. Each button yields a clean stable level, one-cycle press and release pulses, and a one-cycle long-press pulse. It sits directly between the board button pins and the top-level control blocks, replacing the raw `btnL`/`btnU`/`btnD` nets with `btn_press` and `btn_level` bits.

## Interface
- `N_BTN`, 3, number of independent button channels (bit 0 = L, 1 = U, 2 = D in top-level wiring).
- `DEBOUNCE_CYCLES`, 1_000_000, cycles a synchronised input must differ from the stable level before the level flips (10 ms at 100 MHz); legal range ≥ 2.
- `LONG_CYCLES`, 100_000_000, cycles the stable level must stay high before `btn_long` fires (1 s); legal range > `DEBOUNCE_CYCLES`.

- `clk`  input  1  system clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `btn_in`  input  N_BTN  raw, asynchronous button pins; 1 = pressed.
- `btn_level`  output  N_BTN  debounced level per button.
- `btn_press`  output  N_BTN  one-cycle pulse on each debounced 0→1.
- `btn_release`  output  N_BTN  one-cycle pulse on each debounced 1→0.
- `btn_long`  output  N_BTN  one-cycle pulse when a press has been held `LONG_CYCLES` cycles.

## Operation
- All channels are independent and identical; no cross-channel interaction.
- Per channel: 2-flop synchroniser `s1`→`s2`, debounce counter `dcnt` (width clog2(DEBOUNCE_CYCLES)), hold counter `hcnt` (width clog2(LONG_CYCLES)+1), stable register `lvl`, flag `long_done`.
- Reset (asynchronous): `s1`, `s2`, `lvl`, `dcnt`, `hcnt`, `long_done` and all outputs to 0. A button held through reset release is treated as a fresh press and produces `btn_press` after full debounce latency.
- Debounce, each edge:
  - `s2 == lvl`: `dcnt` ← 0 (any bounce back restarts the count).
  - `s2 != lvl` and `dcnt == DEBOUNCE_CYCLES-1`: `lvl` ← `s2`, `dcnt` ← 0.
  - otherwise `dcnt` ← `dcnt`+1.
- Edge pulses are registered: `btn_press` = 1 for exactly the cycle where `lvl` first reads 1; `btn_release` likewise for `lvl` first reading 0. Never both in the same cycle; never two consecutive cycles.
- Long press: while `lvl` = 1 and `long_done` = 0, `hcnt` increments; when `hcnt` reaches LONG_CYCLES-1, `btn_long` pulses for one cycle and `long_done` ← 1. `lvl` = 0 clears `hcnt` and `long_done`. At most one `btn_long` per press; `hcnt` saturates (no wrap).
- `btn_level` = `lvl`.

## Timing
- Raw input changing before edge k and held: `s1` at edge k, `s2` at edge k+1, `lvl` and `btn_press`/`btn_release` update at edge k+1+DEBOUNCE_CYCLES (latency DEBOUNCE_CYCLES+2 edges).
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- `btn_long` asserts at edge LONG_CYCLES after the edge where `btn_press` asserted.
- Minimum debounced pulse width: DEBOUNCE_CYCLES cycles high and low.
- `reset` mid-count: counters and outputs clear immediately (asynchronously); any pulse in flight is dropped.
- No combinational path from `btn_in` to any output.

## Test plan
Bench parameters: N_BTN=3, DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
- Reset with `btn_in`=3'b000, release, idle 20 cycles -> all outputs 0 throughout.
- `btn_in[1]` 0→1 before edge 10, held -> `btn_level[1]` and `btn_press[1]` rise at edge 15, `btn_press[1]` low at edge 16; channels 0 and 2 stay 0.
- `btn_in[0]` bounce 1,0,1,0 each lasting 2 cycles, then steady 1 -> exactly one `btn_press[0]`, occurring 6 edges after steady-1 starts; no `btn_release[0]`.
- Hold `btn_in[2]` for 30 cycles then release -> `btn_press[2]` once, `btn_long[2]` exactly once 10 edges later, `btn_release[2]` once 6 edges after release.
- Press channels 0 and 2 simultaneously -> both `btn_press` bits pulse in the same cycle.
- Assert `reset` 2 cycles after `btn_press[1]`, with `btn_in[1]` still held, then release reset -> outputs 0 immediately; `btn_press[1]` re-fires 6 edges after reset deassertion; no `btn_long` during reset.
